alu_seq: RTL

- Parametrised, registered successor to the CPU's combinational ALU.
- Adds signed and unsigned compare, a full logic-op set, and an iterative unsigned multiply (shift-add) and divide (restoring), each producing a hi/lo result pair.
- Uses a start/ready/resultValid handshake so the multi-cycle datapath can stall the PC update until the result is available.

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_core_comb.sv | 53 +++++
 rtl/alu_seq.sv | 90 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: command codes and FSM states shared by the sequential ALU
package alu_pkg;
  localparam logic [3:0] CMD_ADD  = 4'd0;
  localparam logic [3:0] CMD_SUB  = 4'd1;
  localparam logic [3:0] CMD_XOR  = 4'd2;
  localparam logic [3:0] CMD_SLT  = 4'd3;
  localparam logic [3:0] CMD_AND  = 4'd4;
  localparam logic [3:0] CMD_NAND = 4'd5;
  localparam logic [3:0] CMD_NOR  = 4'd6;
  localparam logic [3:0] CMD_OR   = 4'd7;
  localparam logic [3:0] CMD_SLTU = 4'd8;
  localparam logic [3:0] CMD_MULU = 4'd9;
  localparam logic [3:0] CMD_DIVU = 4'd10;
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
endpackage

// File: rtl/alu_core_comb.sv
// alu_core_comb: single-cycle ops and flags; DIVU here only covers the divide-by-zero case
module alu_core_comb import alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       cmd,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] res_hi,
  output logic             zero,
  output logic             carry,
  output logic             ovf,
  output logic             dbz
);
  logic [WIDTH:0] sum, dif;
  logic slt;
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};
  assign slt = (a[WIDTH-1] != b[WIDTH-1]) ? a[WIDTH-1] : dif[WIDTH-1];
  always_comb begin
    res = '0;
    res_hi = '0;
    carry = 1'b0;
    ovf = 1'b0;
    dbz = 1'b0;
    case (cmd)
      CMD_ADD: begin
        res = sum[WIDTH-1:0];
        carry = sum[WIDTH];
        ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      CMD_SUB: begin
        res = dif[WIDTH-1:0];
        carry = !dif[WIDTH];
        ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      CMD_XOR:  res = a ^ b;
      CMD_SLT:  res = {{(WIDTH-1){1'b0}}, slt};
      CMD_AND:  res = a & b;
      CMD_NAND: res = ~(a & b);
      CMD_NOR:  res = ~(a | b);
      CMD_OR:   res = a | b;
      CMD_SLTU: res = {{(WIDTH-1){1'b0}}, dif[WIDTH]};
      CMD_DIVU: begin
        res = '1;
        res_hi = a;
        dbz = 1'b1;
      end
      default: ;
    endcase
  end
  assign zero = res == '0;
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with iterative shift-add multiply and restoring divide
module alu_seq import alu_pkg::*; #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       aluCommand,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             ready,
  output logic             resultValid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] resultHi,
  output logic             zero,
  output logic             carryOut,
  output logic             overflow,
  output logic             divByZero
);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [2*WIDTH-1:0] acc, mul_next, div_next, step;
  logic [WIDTH-1:0] opnd, c_res, c_hi;
  logic [WIDTH:0] mul_sum, div_shift, div_diff;
  logic c_zero, c_carry, c_ovf, c_dbz, last, multi;
  alu_core_comb #(.WIDTH(WIDTH)) core (
    .cmd(aluCommand), .a(opA), .b(opB), .res(c_res), .res_hi(c_hi),
    .zero(c_zero), .carry(c_carry), .ovf(c_ovf), .dbz(c_dbz)
  );
  // acc holds {hi, lo} for MUL and {remainder, dividend/quotient} for DIV
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
  assign mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
  assign div_shift = acc[2*WIDTH-1:WIDTH-1];
  assign div_diff = div_shift - {1'b0, opnd};
  assign div_next = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  assign step = (state == MUL) ? mul_next : div_next;
  assign last = cnt == CNT_W'(WIDTH - 1);
  assign multi = (aluCommand == CMD_MULU) || (aluCommand == CMD_DIVU && opB != '0);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ready <= 1'b1;
      resultValid <= 1'b0;
      result <= '0;
      resultHi <= '0;
      zero <= 1'b0;
      carryOut <= 1'b0;
      overflow <= 1'b0;
      divByZero <= 1'b0;
      cnt <= '0;
      acc <= '0;
      opnd <= '0;
    end else begin
      resultValid <= 1'b0;
      if (state == IDLE) begin
        if (start && multi) begin
          state <= (aluCommand == CMD_MULU) ? MUL : DIV;
          ready <= 1'b0;
          cnt <= '0;
          acc <= {{WIDTH{1'b0}}, opA};
          opnd <= opB;
        end else if (start) begin
          resultValid <= 1'b1;
          result <= c_res;
          resultHi <= c_hi;
          zero <= c_zero;
          carryOut <= c_carry;
          overflow <= c_ovf;
          divByZero <= c_dbz;
        end
      end else begin
        acc <= step;
        cnt <= cnt + CNT_W'(1);
        if (last) begin
          state <= IDLE;
          ready <= 1'b1;
          resultValid <= 1'b1;
          result <= step[WIDTH-1:0];
          resultHi <= step[2*WIDTH-1:WIDTH];
          zero <= step[WIDTH-1:0] == '0;
          carryOut <= 1'b0;
          overflow <= 1'b0;
          divByZero <= 1'b0;
        end
      end
    end
  end
endmodule
